// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the pipeline-stage register.
// SKID_BUF_EN selects the 2-entry skid variant; otherwise a single slot is built.
package pipe_stage_reg_pkg;

  localparam int          XLEN   = 32;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

`ifdef SKID_BUF_EN
  localparam logic [1:0]  STAGE_DEPTH = 2'd2;
`else
  localparam logic [1:0]  STAGE_DEPTH = 2'd1;
`endif

  // What the main slot does at the next edge.
  typedef enum logic [1:0] {
    MAIN_HOLD      = 2'd0,
    MAIN_LOAD_IN   = 2'd1,
    MAIN_LOAD_SKID = 2'd2,
    MAIN_DROP      = 2'd3
  } main_op_e;

  // Number of beats held, derived from the two valid flags.
  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One data+valid register slot with synchronous reset, clear (to a given
// value) and load; drop invalidates the slot without touching the data.
module pipe_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val,
  input  logic             clear,
  input  logic [WIDTH-1:0] clear_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drop,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  // Slot state update: reset > clear > load > drop > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= rst_val;
    end else if (clear) begin
      valid_r <= 1'b0;
      data_r  <= clear_val;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (drop) begin
      valid_r <= 1'b0;
      data_r  <= data_r;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake and flush-to-bubble.
// Define SKID_BUF_EN for the 2-entry skid variant whose in_ready depends only
// on registered state; without it a single slot with combinational ready is built.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  logic             main_valid_s;
  logic [WIDTH-1:0] main_data_s;
  logic             skid_valid_s;
  logic [WIDTH-1:0] skid_data_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             release_s;
  main_op_e         main_op_s;
  logic             main_load_s;
  logic             main_drop_s;
  logic [WIDTH-1:0] main_load_data_s;
`ifdef SKID_BUF_EN
  logic             skid_load_s;
  logic             skid_drop_s;
`endif

`ifdef SKID_BUF_EN
  // Ready only from the skid flag, so out_ready never reaches in_ready.
  assign in_ready_s = ~rst & ~flush & ~skid_valid_s;
`else
  // Single slot: can take a beat when empty or when it drains this cycle.
  assign in_ready_s = ~rst & ~flush & (~main_valid_s | out_ready);
`endif

  assign accept_s  = in_valid & in_ready_s;
  assign release_s = main_valid_s & out_ready;

  // Choose the next-edge action for the main (and skid) slot.
  always_comb begin
    main_op_s = MAIN_HOLD;
`ifdef SKID_BUF_EN
    skid_load_s = 1'b0;
    skid_drop_s = 1'b0;
    if (release_s) begin
      if (skid_valid_s) begin
        main_op_s   = MAIN_LOAD_SKID;
        skid_drop_s = 1'b1;
      end else if (accept_s) begin
        main_op_s = MAIN_LOAD_IN;
      end else begin
        main_op_s = MAIN_DROP;
      end
    end else begin
      if (accept_s && main_valid_s) begin
        skid_load_s = 1'b1;
      end else if (accept_s) begin
        main_op_s = MAIN_LOAD_IN;
      end else begin
        main_op_s = MAIN_HOLD;
      end
    end
`else
    if (accept_s) begin
      main_op_s = MAIN_LOAD_IN;
    end else if (release_s) begin
      main_op_s = MAIN_DROP;
    end else begin
      main_op_s = MAIN_HOLD;
    end
`endif
  end

  // Decode the main-slot action into slot controls.
  always_comb begin
    main_load_s      = 1'b0;
    main_drop_s      = 1'b0;
    main_load_data_s = in_data;
    case (main_op_s)
      MAIN_HOLD: begin
        main_load_s = 1'b0;
      end
      MAIN_LOAD_IN: begin
        main_load_s      = 1'b1;
        main_load_data_s = in_data;
      end
      MAIN_LOAD_SKID: begin
        main_load_s      = 1'b1;
        main_load_data_s = skid_data_s;
      end
      MAIN_DROP: begin
        main_drop_s = 1'b1;
      end
      default: begin
        main_load_s = 1'b0;
        main_drop_s = 1'b0;
      end
    endcase
  end

  pipe_slot #(.WIDTH(WIDTH)) u_main_slot (
    .clk       (clk),
    .rst       (rst),
    .rst_val   (RST_VAL),
    .clear     (flush),
    .clear_val (BUBBLE_VAL),
    .load      (main_load_s),
    .load_data (main_load_data_s),
    .drop      (main_drop_s),
    .valid     (main_valid_s),
    .data      (main_data_s)
  );

`ifdef SKID_BUF_EN
  pipe_slot #(.WIDTH(WIDTH)) u_skid_slot (
    .clk       (clk),
    .rst       (rst),
    .rst_val   ({WIDTH{1'b0}}),
    .clear     (flush),
    .clear_val ({WIDTH{1'b0}}),
    .load      (skid_load_s),
    .load_data (in_data),
    .drop      (skid_drop_s),
    .valid     (skid_valid_s),
    .data      (skid_data_s)
  );
`else
  assign skid_valid_s = 1'b0;
  assign skid_data_s  = {WIDTH{1'b0}};
`endif

  assign in_ready  = in_ready_s;
  assign out_valid = main_valid_s;
  assign out_data  = main_data_s;
  assign occupancy = occ_count(main_valid_s, skid_valid_s);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; follows SKID_BUF_EN like the design.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam logic [31:0] RSTV = 32'hA5A5_0001;
  localparam logic [31:0] BUB  = RV_NOP;
  localparam int          DEPTH = int'(STAGE_DEPTH);

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];
  logic [31:0] m_idle;
  logic        acc;
  logic        hold;
  logic        r_iv, r_ordy, r_fl;
  logic [31:0] r_id;
  int          idx;
  logic [31:0] lst [3];

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .RST_VAL(RSTV), .BUBBLE_VAL(BUB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the model mid-cycle, update model, advance.
  task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy,
                       input logic fl, input logic rs, output logic accepted);
    logic exp_rdy;
    logic rel;
    rst = rs; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    #3;
`ifdef SKID_BUF_EN
    exp_rdy = !rs && !fl && (sb.size() < 2);
`else
    exp_rdy = !rs && !fl && ((sb.size() == 0) || ordy);
`endif
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
    check_eq("occupancy", {30'd0, occupancy}, 32'(sb.size()));
    check_eq("out_data", out_data, (sb.size() != 0) ? sb[0] : m_idle);
    accepted = iv && exp_rdy;
    rel = (sb.size() != 0) && ordy && !rs;
    if (rel) m_idle = sb.pop_front();
    if (accepted) sb.push_back(id);
    if (rs) begin
      sb.delete();
      m_idle = RSTV;
    end else if (fl) begin
      sb.delete();
      m_idle = BUB;
    end
    @(posedge clk);
    #1;
  endtask

  // Drain with out_ready=1 under a cycle bound.
  task automatic drain(input string tag);
    logic a;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, a);
    check_eq(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    m_idle = RSTV;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset holds everything idle even with in_valid=1
    cycle(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, acc);
    check_eq("t1_rst_data", out_data, RSTV);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, acc);

    // 2: back-to-back stream, one per cycle
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 32'(i), 1'b1, 1'b0, 1'b0, acc);
      check_eq("t2_accept", {31'd0, acc}, 32'd1);
    end
    drain("t2_drain");

    // 3: stall downstream while sending A,B,C
    lst[0] = 32'hA; lst[1] = 32'hB; lst[2] = 32'hC;
    idx = 0;
    repeat (3) begin
      cycle(1'b1, lst[idx], 1'b0, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check_eq("t3_held", 32'(idx), 32'(DEPTH));
    check_eq("t3_occ", {30'd0, occupancy}, 32'(DEPTH));
    for (int i = 0; i < 20 && (idx < 3 || sb.size() != 0); i++) begin
      cycle(idx < 3, lst[(idx < 3) ? idx : 0], 1'b1, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check_eq("t3_all_sent", 32'(idx), 32'd3);
    drain("t3_drain");

    // 4: fill, then flush with a concurrent beat 0xD
    idx = 0;
    lst[0] = 32'h21; lst[1] = 32'h22;
    for (int i = 0; i < 4 && idx < DEPTH; i++) begin
      cycle(1'b1, lst[idx], 1'b0, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    cycle(1'b1, 32'hD, 1'b0, 1'b1, 1'b0, acc);
    check_eq("t4_bubble", out_data, BUB);
    check_eq("t4_occ", {30'd0, occupancy}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc);

    // 5: reset mid-stream with the stage full, then restart
    idx = 0;
    lst[0] = 32'h41; lst[1] = 32'h42;
    for (int i = 0; i < 4 && idx < DEPTH; i++) begin
      cycle(1'b1, lst[idx], 1'b0, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    cycle(1'b1, 32'h77, 1'b1, 1'b0, 1'b1, acc);
    check_eq("t5_rst_data", out_data, RSTV);
    check_eq("t5_occ", {30'd0, occupancy}, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h31 + 32'(i), 1'b1, 1'b0, 1'b0, acc);
    drain("t5_drain");

    // 6: random traffic with producer hold and rare flush
    hold = 1'b0; r_iv = 1'b0; r_id = 32'd0;
    for (int n = 0; n < 10000; n++) begin
      if (!hold) begin
        r_iv = 1'($urandom_range(0, 1));
        r_id = $urandom;
      end
      r_ordy = 1'($urandom_range(0, 1));
      r_fl   = ($urandom_range(0, 299) == 0);
      cycle(r_iv, r_id, r_ordy, r_fl, 1'b0, acc);
      hold = r_iv && !acc && !r_fl;
    end
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
